// File: rtl/r_alu_share_ctrl.sv
// r_alu_share_ctrl: round-robin sharing of one combinational RV32 R-type ALU
// between NREQ requesters. A granted request drives the ALU. Its result, the
// requester index and the tag are captured in a one-entry output slot. The
// slot is drained over a valid/ready response channel, and a new result can
// replace the old one on the same edge that the old one is taken.
module r_alu_share_ctrl #(
  parameter int NREQ = 2,
  parameter int XLEN = 32,
  parameter int TAGW = 5
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic [NREQ-1:0]          req_valid_i,
  output logic [NREQ-1:0]          req_ready_o,
  input  logic [NREQ*32-1:0]       req_instr_i,
  input  logic [NREQ*XLEN-1:0]     req_rv1_i,
  input  logic [NREQ*XLEN-1:0]     req_rv2_i,
  input  logic [NREQ*TAGW-1:0]     req_tag_i,
  output logic [31:0]              alu_idata_o,
  output logic [XLEN-1:0]          alu_rv1_o,
  output logic [XLEN-1:0]          alu_rv2_o,
  input  logic [XLEN-1:0]          alu_result_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [XLEN-1:0]          rsp_data_o,
  output logic [$clog2(NREQ)-1:0]  rsp_id_o,
  output logic [TAGW-1:0]          rsp_tag_o,
  output logic                     rsp_err_o
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  slot_state_e state_q, state_d;

  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [XLEN-1:0] data_q;
  logic [IDW-1:0]  id_q;
  logic [TAGW-1:0] tag_q;
  logic            err_q;

  // Per-requester views of the packed input buses.
  logic [31:0]     instr_arr [NREQ];
  logic [XLEN-1:0] rv1_arr   [NREQ];
  logic [XLEN-1:0] rv2_arr   [NREQ];
  logic [TAGW-1:0] tag_arr   [NREQ];
  // cand_idx[k] is the requester checked k-th, counting from the RR pointer.
  logic [IDW-1:0]  cand_idx  [NREQ];

  logic            grant_any;
  logic [IDW-1:0]  grant_idx;
  logic [NREQ-1:0] grant_vec;
  logic            can_accept;
  logic            accept;
  logic            instr_legal;
  logic [IDW-1:0]  ptr_after_grant;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    logic [IDW:0] sum;
    assign instr_arr[gi] = req_instr_i[gi*32 +: 32];
    assign rv1_arr[gi]   = req_rv1_i[gi*XLEN +: XLEN];
    assign rv2_arr[gi]   = req_rv2_i[gi*XLEN +: XLEN];
    assign tag_arr[gi]   = req_tag_i[gi*TAGW +: TAGW];
    // Pointer plus offset, wrapped modulo NREQ (the sum never reaches 2*NREQ).
    assign sum           = {1'b0, ptr_q} + (IDW+1)'(gi);
    assign cand_idx[gi]  = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ))
                                                   : sum[IDW-1:0];
  end

  // Legal R-type: OP opcode, funct7 zero, or 0100000 only for SUB/SRA.
  function automatic logic is_legal_rtype(input logic [31:0] ins);
    logic alt_ok;
    alt_ok = (ins[31:25] == 7'b0100000) &&
             ((ins[14:12] == 3'b000) || (ins[14:12] == 3'b101));
    return (ins[6:0] == 7'b0110011) && ((ins[31:25] == 7'b0000000) || alt_ok);
  endfunction

  // Round-robin arbiter: first valid requester at or after the pointer.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    grant_vec = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_any && req_valid_i[cand_idx[k]]) begin
        grant_any = 1'b1;
        grant_idx = cand_idx[k];
      end
    end
    if (grant_any) begin
      grant_vec[grant_idx] = 1'b1;
    end
  end

  // Steer the granted requester onto the shared ALU, or zeros when idle.
  always_comb begin
    alu_idata_o = '0;
    alu_rv1_o   = '0;
    alu_rv2_o   = '0;
    if (grant_any) begin
      alu_idata_o = instr_arr[grant_idx];
      alu_rv1_o   = rv1_arr[grant_idx];
      alu_rv2_o   = rv2_arr[grant_idx];
    end
  end

  assign instr_legal     = is_legal_rtype(alu_idata_o);
  assign ptr_after_grant = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

  // Slot FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SLOT_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Slot FSM next state: flush empties, accept fills, a drain without refill empties.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = SLOT_EMPTY;
    end else if (accept) begin
      state_d = SLOT_FULL;
    end else if ((state_q == SLOT_FULL) && rsp_ready_i) begin
      state_d = SLOT_EMPTY;
    end
  end

  // Slot FSM outputs: accept only into a free or draining slot, never during flush or reset.
  always_comb begin
    can_accept  = ((state_q == SLOT_EMPTY) || rsp_ready_i) && !flush_i;
    accept      = can_accept && grant_any;
    req_ready_o = (can_accept && rst_ni) ? grant_vec : '0;
    rsp_valid_o = (state_q == SLOT_FULL);
  end

  // Round-robin pointer moves past the winner; flush restarts it at 0.
  always_comb begin
    ptr_d = ptr_q;
    if (flush_i) begin
      ptr_d = '0;
    end else if (accept) begin
      ptr_d = ptr_after_grant;
    end
  end

  // Pointer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Capture the result on accept; illegal encodings report an error with zero data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      id_q   <= '0;
      tag_q  <= '0;
      err_q  <= 1'b0;
    end else if (accept) begin
      data_q <= instr_legal ? alu_result_i : '0;
      id_q   <= grant_idx;
      tag_q  <= tag_arr[grant_idx];
      err_q  <= !instr_legal;
    end
  end

  assign rsp_data_o = data_q;
  assign rsp_id_o   = id_q;
  assign rsp_tag_o  = tag_q;
  assign rsp_err_o  = err_q;

endmodule

// File: tb/tb_r_alu_share_ctrl.sv
// tb_r_alu_share_ctrl: directed vectors with hand-computed expectations for
// the shared R-type ALU controller. The external ALU is modelled
// combinationally here.
module tb_r_alu_share_ctrl;

  localparam int NREQ = 2;
  localparam int XLEN = 32;
  localparam int TAGW = 5;

  logic                 clk;
  logic                 rst_n;
  logic                 flush;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*32-1:0]   req_instr;
  logic [NREQ*XLEN-1:0] req_rv1;
  logic [NREQ*XLEN-1:0] req_rv2;
  logic [NREQ*TAGW-1:0] req_tag;
  logic [31:0]          alu_idata;
  logic [XLEN-1:0]      alu_rv1;
  logic [XLEN-1:0]      alu_rv2;
  logic [XLEN-1:0]      alu_result;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [XLEN-1:0]      rsp_data;
  logic [0:0]           rsp_id;
  logic [TAGW-1:0]      rsp_tag;
  logic                 rsp_err;

  int n_checks = 0;
  int n_errors = 0;

  r_alu_share_ctrl #(.NREQ(NREQ), .XLEN(XLEN), .TAGW(TAGW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .flush_i      (flush),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_instr_i  (req_instr),
    .req_rv1_i    (req_rv1),
    .req_rv2_i    (req_rv2),
    .req_tag_i    (req_tag),
    .alu_idata_o  (alu_idata),
    .alu_rv1_o    (alu_rv1),
    .alu_rv2_o    (alu_rv2),
    .alu_result_i (alu_result),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_data_o   (rsp_data),
    .rsp_id_o     (rsp_id),
    .rsp_tag_o    (rsp_tag),
    .rsp_err_o    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External combinational ALU.
  always_comb begin
    alu_result = '0;
    case (alu_idata[14:12])
      3'd0: alu_result = alu_idata[30] ? alu_rv1 - alu_rv2 : alu_rv1 + alu_rv2;
      3'd1: alu_result = alu_rv1 << alu_rv2[4:0];
      3'd2: alu_result = {31'b0, $signed(alu_rv1) < $signed(alu_rv2)};
      3'd3: alu_result = {31'b0, alu_rv1 < alu_rv2};
      3'd4: alu_result = alu_rv1 ^ alu_rv2;
      3'd5: alu_result = alu_idata[30] ? 32'($signed(alu_rv1) >>> alu_rv2[4:0])
                                       : alu_rv1 >> alu_rv2[4:0];
      3'd6: alu_result = alu_rv1 | alu_rv2;
      default: alu_result = alu_rv1 & alu_rv2;
    endcase
  end

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_rsp(input string tag, input logic [31:0] data,
                           input logic [31:0] id, input logic [31:0] tg,
                           input logic [31:0] err);
    check({tag, "_valid"}, {31'b0, rsp_valid}, 32'd1);
    check({tag, "_data"}, rsp_data, data);
    check({tag, "_id"}, {31'b0, rsp_id}, id);
    check({tag, "_tag"}, {27'b0, rsp_tag}, tg);
    check({tag, "_err"}, {31'b0, rsp_err}, err);
    $display("txn %s: data=0x%08h id=%0d tag=%0d err=%0d", tag, rsp_data, rsp_id, rsp_tag, rsp_err);
  endtask

  task automatic set_req(input int i, input logic [31:0] ins, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tg);
    req_instr[i*32 +: 32]     = ins;
    req_rv1[i*XLEN +: XLEN]   = a;
    req_rv2[i*XLEN +: XLEN]   = b;
    req_tag[i*TAGW +: TAGW]   = tg;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ADD, SUB, SRA, SLTU, ILL;
    ADD  = mk(7'h00, 3'd0);
    SUB  = mk(7'h20, 3'd0);
    SRA  = mk(7'h20, 3'd5);
    SLTU = mk(7'h00, 3'd3);
    ILL  = mk(7'h20, 3'd7);

    rst_n = 1'b0; flush = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    req_instr = '0; req_rv1 = '0; req_rv2 = '0; req_tag = '0;

    // Reset state, with requests pending
    #3;
    set_req(0, ADD, 32'd5, 32'd7, 5'd3);
    req_valid = 2'b11;
    #1;
    check("rst_ready", {30'b0, req_ready}, 32'd0);
    check("rst_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_data", rsp_data, 32'd0);
    check("rst_tag", {27'b0, rsp_tag}, 32'd0);
    check("rst_err", {31'b0, rsp_err}, 32'd0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // 1: single ADD from requester 0
    set_req(0, ADD, 32'd5, 32'd7, 5'd3);
    req_valid = 2'b01; rsp_ready = 1'b1;
    #1;
    check("t1_ready", {30'b0, req_ready}, 32'd1);
    check("t1_alu_idata", alu_idata, ADD);
    check("t1_alu_rv2", alu_rv2, 32'd7);
    step();
    req_valid = '0;
    check_rsp("t1", 32'd12, 0, 3, 0);
    #1;
    check("t1_idle_idata", alu_idata, 32'd0);

    // Flush restarts the pointer (it sits at 1 now) and empties the slot
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fl_valid", {31'b0, rsp_valid}, 32'd0);

    // 2: both valid, alternating grants 0,1,0,1
    set_req(0, ADD, 32'd5, 32'd7, 5'd3);
    set_req(1, SUB, 32'd10, 32'd3, 5'd4);
    req_valid = 2'b11; rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t2_ready", {30'b0, req_ready}, (k % 2 == 0) ? 32'd1 : 32'd2);
      step();
      if (k % 2 == 0) check_rsp("t2_r0", 32'd12, 0, 3, 0);
      else            check_rsp("t2_r1", 32'd7, 1, 4, 0);
    end
    req_valid = '0;
    step();
    check("t2_drained", {31'b0, rsp_valid}, 32'd0);

    // 3: SRA from requester 1, stalled for 3 cycles, then taken
    set_req(1, SRA, 32'h8000_0000, 32'd4, 5'd6);
    req_valid = 2'b10; rsp_ready = 1'b0;
    #1;
    check("t3_ready", {30'b0, req_ready}, 32'd2);
    step();
    set_req(0, ADD, 32'd5, 32'd7, 5'd3);
    req_valid = 2'b01;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t3_stall_ready", {30'b0, req_ready}, 32'd0);
      step();
      check_rsp("t3_hold", 32'hF800_0000, 1, 6, 0);
    end
    rsp_ready = 1'b1;
    #1;
    check("t3_b2b_ready", {30'b0, req_ready}, 32'd1);
    step();
    check_rsp("t3_next", 32'd12, 0, 3, 0);

    // 4: funct7=0100000 with AND is illegal
    set_req(0, ILL, 32'h0000_00FF, 32'h0000_000F, 5'd9);
    req_valid = 2'b01; rsp_ready = 1'b1;
    #1;
    check("t4_ready", {30'b0, req_ready}, 32'd1);
    step();
    check_rsp("t4_ill", 32'd0, 0, 9, 1);

    // 5: flush while full with a request pending; the pointer (now 1) returns to 0
    flush = 1'b1; rsp_ready = 1'b0; req_valid = 2'b01;
    #1;
    check("t5_ready", {30'b0, req_ready}, 32'd0);
    step();
    flush = 1'b0;
    check("t5_valid", {31'b0, rsp_valid}, 32'd0);
    set_req(0, SLTU, 32'd1, 32'hFFFF_FFFF, 5'd1);
    set_req(1, ADD, 32'd1, 32'd1, 5'd2);
    req_valid = 2'b11; rsp_ready = 1'b1;
    #1;
    check("t5_ptr0", {30'b0, req_ready}, 32'd1);
    step();
    check_rsp("t5_sltu", 32'd1, 0, 1, 0);

    // 6: asynchronous reset while full
    req_valid = 2'b01;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_valid", {31'b0, rsp_valid}, 32'd0);
    check("t6_data", rsp_data, 32'd0);
    check("t6_ready", {30'b0, req_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    req_valid = '0;
    check_rsp("t6_sltu", 32'd1, 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
